// File: rtl/stream_fifo_unit.sv
// stream_fifo_unit: elastic 32-bit first-word-fall-through stream buffer.
// Circular buffer of DEPTH words with wrap-bit pointers; no combinational
// path from the input side to the output side.
// Optional feature: define STREAM_FIFO_COUNT_EN to add the registered
// occupancy output `count`.
module stream_fifo_unit #(
  parameter int DEPTH    = 4,
  parameter bit tide_rst = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef STREAM_FIFO_COUNT_EN
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
`else
  input  logic                       flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          flush_eff;

  assign flush_eff = flush && !tide_rst;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next pointer values; flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush_eff) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (push) wr_nxt = wr_ptr + PW'(1);
      if (pop)  rd_nxt = rd_ptr + PW'(1);
    end
  end

  // Pointer state, asynchronously cleared so contents drop at once on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

`ifdef STREAM_FIFO_COUNT_EN
  // Registered occupancy, derived from the same next pointers so it moves
  // on exactly the edges the pointers do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= wr_nxt - rd_nxt;
    end
  end
`endif

  // Storage write; a word offered alongside flush is discarded.
  always_ff @(posedge clk) begin
    if (push && !flush_eff) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo_unit.sv
// tb_stream_fifo_unit: scoreboard bench for stream_fifo_unit (DEPTH=4).
// A queue-based reference model follows the handshake rules at each rising
// edge; a monitor on the falling edge compares the DUT against it.
module tb_stream_fifo_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
`ifdef STREAM_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_words  = 0;

  logic [31:0] exp_q[$];

  stream_fifo_unit #(.DEPTH(DEPTH), .tide_rst(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef STREAM_FIFO_COUNT_EN
    .flush     (flush),
    .count     (count)
`else
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a word enters when offered and fewer than DEPTH are held;
  // the head leaves when the consumer is ready and something is held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      int sz;
      sz = exp_q.size();
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && sz > 0) void'(exp_q.pop_front());
        if (in_valid && sz < DEPTH) exp_q.push_back(in_data);
      end
    end
  end

  // Monitor: compare the visible outputs against the model between edges.
  always @(negedge clk) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!rst && exp_q.size() < DEPTH)});
    chk("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
    chk("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
`ifdef STREAM_FIFO_COUNT_EN
    chk("count", 32'(count), 32'(exp_q.size()));
`endif
    if (out_valid && out_ready && exp_q.size() != 0) n_words++;
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #22 rst = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Three pushes with the consumer stalled, then three pops.
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    step(1, 32'h33, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Fill, then offer 0x55 while popping: refused on the full cycle.
    for (int i = 0; i < DEPTH; i++) step(1, 32'hA0 + 32'(i), 0, 0);
    step(1, 32'h55, 1, 0);
    step(1, 32'h55, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0);

    // Continuous streaming across two pointer wraps.
    for (int i = 1; i <= 10; i++) step(1, 32'(i), 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Flush with a simultaneous push and pop.
    step(1, 32'hB1, 0, 0);
    step(1, 32'hB2, 0, 0);
    step(1, 32'h77, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Asynchronous reset between edges with three words held.
    step(1, 32'hC1, 0, 0);
    step(1, 32'hC2, 0, 0);
    step(1, 32'hC3, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 1)), $urandom, logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 19) == 0));
    end

    // Drain.
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0);
    chk("drained_model_empty", 32'(exp_q.size()), 32'h0);
    chk("words_seen_nonzero", {31'b0, (n_words > 20)}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
